penc_dec_seq: RTL and testbench
===============================

Name: penc_dec_seq

Overview:
- Registered index-to-mask decoder: the inverse of the priority encoder.
- Accepts index commands (set/clear/toggle/load-one-hot) and maintains an OPT-wide request mask `Y`.
- `Y` feeds the encoder's `X` input directly.
- Also maintains an incrementally updated population count plus empty/full flags, so downstream logic never needs a wide popcount tree.

Parameters:
- LEN, 4: index width. OPT = 2**LEN is the mask width (localparam).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- V  input  1  command valid, one command per cycle, no backpressure
- OP  input  2  opcode: 0 SET, 1 CLR, 2 TOGGLE, 3 LOAD (one-hot)
- X  input  LEN  target index
- CA  input  1  clear-all strobe
- Y  output  OPT  registered mask
- CNT  output  LEN+1  number of set bits in Y, range 0..OPT
- EMPTY  output  1  CNT == 0, registered
- FULL  output  1  CNT == OPT, registered

Behaviour:
- Reset: sampled at the clk edge while rst_n = 0.
  - Y = 0, CNT = 0, EMPTY = 1, FULL = 0.
  - All other inputs are ignored that cycle.
- Latency: a command sampled at edge k is visible on Y/CNT/EMPTY/FULL immediately after edge k. There is no combinational input-to-output path.
- Implementation is a two-state control: IDLE and UPDATE folded into a single register stage. No multi-cycle states and no ready signal; the block accepts every cycle.
- Priority when several events occur at the same edge: rst_n low > CA > V.
- CA = 1: Y = 0, CNT = 0. Any V command in that cycle is dropped.
- V = 1 with CA = 0 (b = Y[X] before the edge):
  - SET: Y[X] = 1. CNT += 1 if b = 0, else unchanged.
  - CLR: Y[X] = 0. CNT -= 1 if b = 1, else unchanged.
  - TOGGLE: Y[X] = ~b. CNT += 1 if b = 0, else CNT -= 1.
  - LOAD: Y = (1 << X). CNT = 1, regardless of prior contents.
- V = 0, CA = 0: hold all state.
- Arithmetic: CNT is LEN+1 bits and can never wrap.
  - SET on a full mask leaves CNT = OPT (b is already 1).
  - CLR on an empty mask leaves CNT = 0.
- Invariant, checked every cycle: CNT == popcount(Y).
- Flags: EMPTY and FULL are computed from the next-state CNT and registered alongside it.
- Index range: X always addresses a valid bit because OPT = 2**LEN. No out-of-range case exists.

Optional Feature:
- Macro: PENC_DEC_ERR_EN.
- When defined:
  - Adds output `ERR` (1 bit, sticky), reset to 0.
  - ERR is set at the edge where V = 1, CA = 0, and the command is redundant: SET with b = 1, or CLR with b = 0.
  - ERR is cleared only by reset or CA. If CA and a redundant command arrive in the same cycle, CA wins and ERR = 0.
  - Mask and count behaviour are unchanged.
- When undefined: the ERR port does not exist and no error logic is generated.

Test Plan (LEN = 4):
- Reset: hold rst_n = 0 for 2 cycles with V = 1, OP = SET, X = 5, then release. Required: Y = 0x0000, CNT = 0, EMPTY = 1, FULL = 0.
- Sequence SET 3, SET 9, SET 3, then CLR 3. Required:
  - Y = 0x0008, then 0x0208, then 0x0208, then 0x0200.
  - CNT = 1, 2, 2, 1.
  - With ERR_EN, ERR rises after the second SET 3.
- TOGGLE 0 sixteen times then TOGGLE 15 once. Required: Y = 0x8000, CNT = 1; after each toggle of bit 0, CNT alternates 1/0.
- SET all indices 0..15 in order, then SET 7. Required:
  - Y = 0xFFFF and FULL = 1 after the 16th SET; CNT stays 16 after SET 7.
  - Then LOAD 12: Y = 0x1000, CNT = 1, FULL = 0.
- Y = 0x00F0, then the same cycle has CA = 1 and V = 1 with SET 2. Required: Y = 0, CNT = 0, EMPTY = 1, ERR = 0.
- Y = 0x00F0, then rst_n = 0 in the same cycle as CA = 1 and V = 1 with LOAD 4. Required: the reset state.

Source files
------------

// File: rtl/penc_dec_seq.sv
// penc_dec_seq -- registered index-to-mask decoder (inverse of a priority
// encoder). Index commands build an OPT-wide request mask that drives an
// encoder's X input directly. A population count and EMPTY/FULL flags are
// kept incrementally, so no wide popcount tree is ever needed downstream.
//
// Parameters:
//   LEN   index width; the mask is OPT = 2**LEN bits wide
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous reset, active low
//   V      in   command valid (one command per cycle, always accepted)
//   OP     in   2-bit opcode: 0 SET, 1 CLR, 2 TOGGLE, 3 LOAD (one-hot)
//   X      in   LEN-bit target index
//   CA     in   clear-all strobe (beats V)
//   ERR    out  sticky redundant-command flag (only with PENC_DEC_ERR_EN)
//   Y      out  registered mask
//   CNT    out  LEN+1-bit count of set bits in Y
//   EMPTY  out  registered CNT == 0
//   FULL   out  registered CNT == OPT
//
// Optional feature macro: PENC_DEC_ERR_EN adds the sticky ERR output, which
// flags a SET of an already-set bit or a CLR of an already-clear bit.
module penc_dec_seq #(
  parameter int LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                V,
  input  logic [1:0]          OP,
  input  logic [LEN-1:0]      X,
  input  logic                CA,
`ifdef PENC_DEC_ERR_EN
  output logic                ERR,
`endif
  output logic [2**LEN-1:0]   Y,
  output logic [LEN:0]        CNT,
  output logic                EMPTY,
  output logic                FULL
);

  localparam int OPT = 2**LEN;

  localparam logic [1:0] OP_SET  = 2'd0;
  localparam logic [1:0] OP_CLR  = 2'd1;
  localparam logic [1:0] OP_TOG  = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

  localparam logic [LEN:0] CNT_ONE  = (LEN+1)'(1);
  localparam logic [LEN:0] CNT_FULL = (LEN+1)'(OPT);

  logic [OPT-1:0] y_reg, y_next;
  logic [LEN:0]   cnt_reg, cnt_next;
  logic           empty_reg, empty_next;
  logic           full_reg, full_next;

  // One-hot decode of the target index; every mask update is a single
  // OR / AND-NOT / XOR / replace against this vector.
  logic [OPT-1:0] sel;

  genvar gi;
  generate
    for (gi = 0; gi < OPT; gi++) begin : g_sel
      assign sel[gi] = (X == LEN'(gi));
    end
  endgenerate

  // Current value of the addressed bit, taken before the edge.
  logic b;
  assign b = |(y_reg & sel);

  // Command is a no-op on the mask: SET of a 1 or CLR of a 0.
  logic redundant;

  always_comb begin
    y_next    = y_reg;
    cnt_next  = cnt_reg;
    redundant = 1'b0;
    if (CA) begin
      y_next   = '0;
      cnt_next = '0;
    end else if (V) begin
      case (OP)
        OP_SET: begin
          y_next = y_reg | sel;
          if (!b) cnt_next = cnt_reg + CNT_ONE;
          redundant = b;
        end
        OP_CLR: begin
          y_next = y_reg & ~sel;
          if (b) cnt_next = cnt_reg - CNT_ONE;
          redundant = ~b;
        end
        OP_TOG: begin
          y_next   = y_reg ^ sel;
          cnt_next = b ? (cnt_reg - CNT_ONE) : (cnt_reg + CNT_ONE);
        end
        OP_LOAD: begin
          y_next   = sel;
          cnt_next = CNT_ONE;
        end
        default: begin
          y_next   = y_reg;
          cnt_next = cnt_reg;
        end
      endcase
    end
    // Flags follow the next-state count so they line up with CNT.
    empty_next = (cnt_next == '0);
    full_next  = (cnt_next == CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg     <= '0;
      cnt_reg   <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else begin
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
      empty_reg <= empty_next;
      full_reg  <= full_next;
    end
  end

`ifdef PENC_DEC_ERR_EN
  logic err_reg, err_next;

  // Sticky; CA clears it even when a redundant command arrives alongside.
  always_comb begin
    err_next = err_reg;
    if (CA)
      err_next = 1'b0;
    else if (V && redundant)
      err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_reg <= 1'b0;
    else
      err_reg <= err_next;
  end

  assign ERR = err_reg;
`else
  logic unused_redundant;
  assign unused_redundant = redundant;
`endif

  assign Y     = y_reg;
  assign CNT   = cnt_reg;
  assign EMPTY = empty_reg;
  assign FULL  = full_reg;

endmodule

// File: tb/tb_penc_dec_seq.sv
// Directed, self-checking bench for penc_dec_seq (LEN = 4). Expected masks
// and counts are hand-computed constants; ERR checks are compiled in only
// when PENC_DEC_ERR_EN is defined.
`timescale 1ns/1ps
module tb_penc_dec_seq;

  localparam int LEN = 4;

  localparam logic [1:0] SET  = 2'd0;
  localparam logic [1:0] CLR  = 2'd1;
  localparam logic [1:0] TOG  = 2'd2;
  localparam logic [1:0] LOAD = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        V;
  logic [1:0]  OP;
  logic [3:0]  X;
  logic        CA;
  logic [15:0] Y;
  logic [4:0]  CNT;
  logic        EMPTY;
  logic        FULL;
`ifdef PENC_DEC_ERR_EN
  logic        ERR;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  penc_dec_seq #(.LEN(LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .V     (V),
    .OP    (OP),
    .X     (X),
    .CA    (CA),
`ifdef PENC_DEC_ERR_EN
    .ERR   (ERR),
`endif
    .Y     (Y),
    .CNT   (CNT),
    .EMPTY (EMPTY),
    .FULL  (FULL)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Checks mask, count, both flags and the count/popcount invariant.
  task automatic chk_state(input string tag, input logic [15:0] ey, input logic [4:0] ec);
    chk({tag, ".Y"}, 32'(Y), 32'(ey));
    chk({tag, ".CNT"}, 32'(CNT), 32'(ec));
    chk({tag, ".EMPTY"}, 32'(EMPTY), 32'(ec == 5'd0));
    chk({tag, ".FULL"}, 32'(FULL), 32'(ec == 5'd16));
    chk({tag, ".POP"}, 32'($countones(Y)), 32'(CNT));
    $display("%-12s rst_n=%0b V=%0b OP=%0d X=%0d CA=%0b -> Y=%04h CNT=%0d EMPTY=%0b FULL=%0b",
             tag, rst_n, V, OP, X, CA, Y, CNT, EMPTY, FULL);
  endtask

`ifdef PENC_DEC_ERR_EN
  `define CHK_ERR(t, e) chk(t, 32'(ERR), 32'(e))
`else
  `define CHK_ERR(t, e)
`endif

  // Apply one set of inputs across one rising edge, then settle.
  task automatic drive(input logic r, input logic v, input logic [1:0] op,
                       input logic [3:0] x, input logic ca);
    rst_n = r; V = v; OP = op; X = x; CA = ca;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; V = 1'b0; OP = SET; X = 4'd0; CA = 1'b0;

    // Reset held for two cycles with a live SET 5 that must be ignored.
    drive(1'b0, 1'b1, SET, 4'd5, 1'b0);
    chk_state("rst0", 16'h0000, 5'd0);
    drive(1'b0, 1'b1, SET, 4'd5, 1'b0);
    chk_state("rst1", 16'h0000, 5'd0);
    `CHK_ERR("rst1.ERR", 1'b0);
    drive(1'b1, 1'b0, SET, 4'd5, 1'b0);
    chk_state("idle", 16'h0000, 5'd0);

    // CLR on an empty mask: count stays 0, redundant.
    drive(1'b1, 1'b1, CLR, 4'd3, 1'b0);
    chk_state("clr_empty", 16'h0000, 5'd0);
    `CHK_ERR("clr_empty.ERR", 1'b1);
    drive(1'b1, 1'b0, SET, 4'd0, 1'b1);
    chk_state("ca0", 16'h0000, 5'd0);
    `CHK_ERR("ca0.ERR", 1'b0);

    // SET 3, SET 9, SET 3 (redundant), CLR 3.
    drive(1'b1, 1'b1, SET, 4'd3, 1'b0);
    chk_state("set3", 16'h0008, 5'd1);
    `CHK_ERR("set3.ERR", 1'b0);
    drive(1'b1, 1'b1, SET, 4'd9, 1'b0);
    chk_state("set9", 16'h0208, 5'd2);
    `CHK_ERR("set9.ERR", 1'b0);
    drive(1'b1, 1'b1, SET, 4'd3, 1'b0);
    chk_state("set3b", 16'h0208, 5'd2);
    `CHK_ERR("set3b.ERR", 1'b1);
    drive(1'b1, 1'b1, CLR, 4'd3, 1'b0);
    chk_state("clr3", 16'h0200, 5'd1);
    `CHK_ERR("clr3.ERR", 1'b1);

    // V = 0 holds everything.
    drive(1'b1, 1'b0, LOAD, 4'd1, 1'b0);
    chk_state("hold", 16'h0200, 5'd1);

    // Clear, then TOGGLE 0 sixteen times, then TOGGLE 15.
    drive(1'b1, 1'b0, SET, 4'd0, 1'b1);
    chk_state("ca1", 16'h0000, 5'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, TOG, 4'd0, 1'b0);
      chk_state($sformatf("tog0_%0d", i), (i % 2 == 0) ? 16'h0001 : 16'h0000,
                (i % 2 == 0) ? 5'd1 : 5'd0);
    end
    drive(1'b1, 1'b1, TOG, 4'd15, 1'b0);
    chk_state("tog15", 16'h8000, 5'd1);

    // Clear, SET every index in order, then SET 7 on a full mask.
    drive(1'b1, 1'b0, SET, 4'd0, 1'b1);
    chk_state("ca2", 16'h0000, 5'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, SET, 4'(i), 1'b0);
      chk_state($sformatf("fill_%0d", i), 16'((32'd1 << (i + 1)) - 1), 5'(i + 1));
    end
    `CHK_ERR("fill.ERR", 1'b0);
    drive(1'b1, 1'b1, SET, 4'd7, 1'b0);
    chk_state("set7_full", 16'hFFFF, 5'd16);
    `CHK_ERR("set7_full.ERR", 1'b1);
    drive(1'b1, 1'b1, LOAD, 4'd12, 1'b0);
    chk_state("load12", 16'h1000, 5'd1);
    `CHK_ERR("load12.ERR", 1'b1);

    // Build 0x00F0, then CA with SET 2 in the same cycle.
    drive(1'b1, 1'b1, LOAD, 4'd4, 1'b0);
    chk_state("load4", 16'h0010, 5'd1);
    drive(1'b1, 1'b1, SET, 4'd5, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd6, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd7, 1'b0);
    chk_state("f0_a", 16'h00F0, 5'd4);
    drive(1'b1, 1'b1, SET, 4'd2, 1'b1);
    chk_state("ca_set2", 16'h0000, 5'd0);
    `CHK_ERR("ca_set2.ERR", 1'b0);

    // Rebuild 0x00F0, raise ERR, then CA with a redundant SET 4: CA wins.
    drive(1'b1, 1'b1, LOAD, 4'd4, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd5, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd6, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd7, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd7, 1'b0);
    chk_state("f0_b", 16'h00F0, 5'd4);
    `CHK_ERR("f0_b.ERR", 1'b1);
    drive(1'b1, 1'b1, SET, 4'd4, 1'b1);
    chk_state("ca_set4", 16'h0000, 5'd0);
    `CHK_ERR("ca_set4.ERR", 1'b0);

    // Rebuild 0x00F0 with ERR set, then reset + CA + LOAD 4 together.
    drive(1'b1, 1'b1, LOAD, 4'd4, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd5, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd6, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd7, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd4, 1'b0);
    chk_state("f0_c", 16'h00F0, 5'd4);
    drive(1'b0, 1'b1, LOAD, 4'd4, 1'b1);
    chk_state("rst_ca_load", 16'h0000, 5'd0);
    `CHK_ERR("rst_ca_load.ERR", 1'b0);

    // Toggle off a set bit to exercise the decrement path.
    drive(1'b1, 1'b1, LOAD, 4'd10, 1'b0);
    drive(1'b1, 1'b1, SET, 4'd11, 1'b0);
    chk_state("ab", 16'h0C00, 5'd2);
    drive(1'b1, 1'b1, TOG, 4'd10, 1'b0);
    chk_state("tog10", 16'h0800, 5'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
